exc_sequencer: RTL and testbench

//  Sequences exception entry/return for the LEGv8 core. Takes the decoder's Exc/EStatus/ERet
//  and the device IRQ request, captures ELR/ESR, flushes the pipeline for a fixed number of

---
 rtl/exc_pkg.sv | 42 ++++
 rtl/exc_stat_counters.sv | 38 +++
 rtl/exc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_exc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types for exception sequencing: EStatus codes, sequencer states, PC mux selects.
// Also used by the main decoder and the fetch PC mux.
package exc_pkg;

   typedef enum logic [3:0] {
      ES_NONE  = 4'b0000,
      ES_IRQ   = 4'b0001,
      ES_UNDEF = 4'b0010
   } estatus_t;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_HANDLER  = 3'd3,
      ST_HALT     = 3'd4
   } exc_state_t;

   typedef enum logic [1:0] {
      PCSEL_SEQ = 2'b00,
      PCSEL_VEC = 2'b01,
      PCSEL_ELR = 2'b10
   } pc_sel_t;

   // An ERET outside a handler is reported with the same code as an undefined instruction.
   localparam logic [3:0] ESR_STRAY_ERET = 4'b0010;

   localparam int NUM_CAUSES   = 4;
   localparam int CAUSE_IRQ    = 0;
   localparam int CAUSE_UNDEF  = 1;
   localparam int CAUSE_ERET   = 2;
   localparam int CAUSE_DFAULT = 3;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/exc_stat_counters.sv
// Per-cause 16-bit saturating exception counters with a combinational read port.
// Only built when EXC_STATS_EN is defined.
`ifdef EXC_STATS_EN
module exc_stat_counters
   import exc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_CAUSES-1:0] inc_i,
   input  logic [1:0]            sel_i,
   output logic [15:0]           stat_o
);

   logic [15:0] cnt_q [NUM_CAUSES];
   logic [15:0] cnt_d [NUM_CAUSES];

   // Next counter values: bump the cause that fired this cycle.
   always_comb begin
      for (int i = 0; i < NUM_CAUSES; i++) begin
         cnt_d[i] = inc_i[i] ? sat_inc16(cnt_q[i]) : cnt_q[i];
      end
   end

   // Counter registers, cleared by the synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CAUSES; i++) begin
            cnt_q[i] <= 16'h0000;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stat_o = cnt_q[sel_i];

endmodule
`endif

// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer: captures ELR/ESR, flushes, redirects to the vector, handles ERET.
// Define EXC_STATS_EN to add per-cause counters and the stat_sel_i/stat_o read port.
module exc_sequencer
   import exc_pkg::*;
#(
   parameter int              PC_W        = 64,
   parameter logic [PC_W-1:0] VECTOR_ADDR = 64'hD8,
   parameter int              FLUSH_CYC   = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            exc_i,
   input  logic [3:0]      estatus_i,
   input  logic            eret_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic            irq_req_i,
   output logic            irq_ack_o,
   output logic            flush_o,
   output logic            stall_o,
   output logic [1:0]      pc_sel_o,
   output logic [PC_W-1:0] elr_o,
   output logic [3:0]      esr_o,
   output logic            in_handler_o,
   output logic            halted_o
`ifdef EXC_STATS_EN
   ,
   input  logic [1:0]      stat_sel_i,
   output logic [15:0]     stat_o
`endif
);

   localparam int CNT_W = $clog2(FLUSH_CYC + 1);

   // The vector itself is muxed downstream; here we only refuse unusable configurations.
   if (FLUSH_CYC < 1 || VECTOR_ADDR[1:0] != 2'b00) begin : g_bad_cfg
      $error("exc_sequencer: FLUSH_CYC must be >= 1 and VECTOR_ADDR word aligned");
   end

   exc_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0] elr_q, elr_d;
   logic [3:0]      esr_q, esr_d;
   logic            irq_ack_q, irq_ack_d;
   logic            flush_q, flush_d;
   logic            stall_q, stall_d;
   pc_sel_t         pc_sel_q, pc_sel_d;
   logic            in_handler_q, in_handler_d;
   logic            halted_q, halted_d;

   // State, flush counter and registered outputs; reset is synchronous active-low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         cnt_q        <= {CNT_W{1'b0}};
         elr_q        <= {PC_W{1'b0}};
         esr_q        <= 4'b0000;
         irq_ack_q    <= 1'b0;
         flush_q      <= 1'b0;
         stall_q      <= 1'b0;
         pc_sel_q     <= PCSEL_SEQ;
         in_handler_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         elr_q        <= elr_d;
         esr_q        <= esr_d;
         irq_ack_q    <= irq_ack_d;
         flush_q      <= flush_d;
         stall_q      <= stall_d;
         pc_sel_q     <= pc_sel_d;
         in_handler_q <= in_handler_d;
         halted_q     <= halted_d;
      end
   end

   // Next state and the output values that go with it.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      elr_d        = elr_q;
      esr_d        = esr_q;
      irq_ack_d    = 1'b0;
      flush_d      = 1'b0;
      stall_d      = 1'b0;
      pc_sel_d     = PCSEL_SEQ;
      in_handler_d = 1'b0;
      halted_d     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (irq_req_i || exc_i || eret_i) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYC - 1);
               elr_d   = pc_i;
               flush_d = 1'b1;
               stall_d = 1'b1;
               if (irq_req_i) begin
                  esr_d     = ES_IRQ;
                  irq_ack_d = 1'b1;
               end else if (exc_i) begin
                  esr_d = estatus_i;
               end else begin
                  esr_d = ESR_STRAY_ERET;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d  = ST_REDIRECT;
               pc_sel_d = PCSEL_VEC;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               flush_d = 1'b1;
               stall_d = 1'b1;
            end
         end
         ST_REDIRECT: begin
            state_d      = ST_HANDLER;
            in_handler_d = 1'b1;
         end
         ST_HANDLER: begin
            // A fault inside the handler beats a simultaneous ERET.
            if (exc_i) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               stall_d  = 1'b1;
               flush_d  = 1'b1;
            end else if (eret_i) begin
               state_d  = ST_RUN;
               pc_sel_d = PCSEL_ELR;
               flush_d  = 1'b1;
            end else begin
               in_handler_d = 1'b1;
            end
         end
         ST_HALT: begin
            halted_d = 1'b1;
            stall_d  = 1'b1;
            flush_d  = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign irq_ack_o    = irq_ack_q;
   assign flush_o      = flush_q;
   assign stall_o      = stall_q;
   assign pc_sel_o     = pc_sel_q;
   assign elr_o        = elr_q;
   assign esr_o        = esr_q;
   assign in_handler_o = in_handler_q;
   assign halted_o     = halted_q;

`ifdef EXC_STATS_EN
   logic [NUM_CAUSES-1:0] stat_inc;

   // One capture event per cycle, classified with the same priority as ESR.
   always_comb begin
      stat_inc               = {NUM_CAUSES{1'b0}};
      stat_inc[CAUSE_IRQ]    = (state_q == ST_RUN) && irq_req_i;
      stat_inc[CAUSE_UNDEF]  = (state_q == ST_RUN) && !irq_req_i && exc_i;
      stat_inc[CAUSE_ERET]   = (state_q == ST_RUN) && !irq_req_i && !exc_i && eret_i;
      stat_inc[CAUSE_DFAULT] = (state_q == ST_HANDLER) && exc_i;
   end

   exc_stat_counters u_stats (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (stat_inc),
      .sel_i  (stat_sel_i),
      .stat_o (stat_o)
   );
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: random decoder/IRQ traffic against a timeline-based model.
// Compile with EXC_STATS_EN to also check the per-cause counters.
module tb_exc_sequencer;
   import exc_pkg::*;

   localparam int PC_W      = 64;
   localparam int FLUSH_CYC = 3;

   logic        clk = 1'b0;
   logic        reset, exc, eret, irq_req;
   logic [3:0]  estatus;
   logic [63:0] pc;
   logic        irq_ack, flush, stall, in_handler, halted;
   logic [1:0]  pc_sel;
   logic [63:0] elr;
   logic [3:0]  esr;
`ifdef EXC_STATS_EN
   logic [1:0]  stat_sel;
   logic [15:0] stat;
`endif

   always #5 clk = ~clk;

   exc_sequencer #(.PC_W(PC_W), .VECTOR_ADDR(64'hD8), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clk          (clk),
      .reset        (reset),
      .exc_i        (exc),
      .estatus_i    (estatus),
      .eret_i       (eret),
      .pc_i         (pc),
      .irq_req_i    (irq_req),
      .irq_ack_o    (irq_ack),
      .flush_o      (flush),
      .stall_o      (stall),
      .pc_sel_o     (pc_sel),
      .elr_o        (elr),
      .esr_o        (esr),
      .in_handler_o (in_handler),
      .halted_o     (halted)
`ifdef EXC_STATS_EN
      ,
      .stat_sel_i   (stat_sel),
      .stat_o       (stat)
`endif
   );

   typedef struct packed {
      logic        ack;
      logic        flush;
      logic        stall;
      logic [1:0]  pc_sel;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic        in_h;
      logic        halted;
      logic [15:0] stat;
   } obs_t;

   obs_t sb[$];
   obs_t exp_e, got_e;
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model, expressed as a timeline: a capture at edge n puts the vector fetch at
   // edge n+FLUSH_CYC and handler entry one edge later.
   int          m_n = 0;
   int          m_vec_at = -1;
   bit          m_handler = 1'b0;
   bit          m_halted = 1'b0;
   int          m_halt_cyc = 0;
   logic [63:0] m_elr = 64'h0;
   logic [3:0]  m_esr = 4'h0;
   int          m_cnt[4] = '{0, 0, 0, 0};

   function automatic void bump(input int k);
      if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
   endfunction

   task automatic step(input bit r, input bit i_irq, input bit i_exc, input logic [3:0] i_es,
                       input bit i_eret, input logic [63:0] i_pc, input logic [1:0] i_sel);
      obs_t e;
      e       = '0;
      reset   = r;
      irq_req = i_irq;
      exc     = i_exc;
      estatus = i_es;
      eret    = i_eret;
      pc      = i_pc;
`ifdef EXC_STATS_EN
      stat_sel = i_sel;
`endif
      if (!r) begin
         m_vec_at   = -1;
         m_handler  = 1'b0;
         m_halted   = 1'b0;
         m_halt_cyc = 0;
         m_elr      = 64'h0;
         m_esr      = 4'h0;
         for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (m_halted) begin
         e.halted = 1'b1; e.stall = 1'b1; e.flush = 1'b1;
         m_halt_cyc = m_halt_cyc + 1;
      end else if (m_vec_at >= 0) begin
         if (m_n < m_vec_at) begin
            e.flush = 1'b1; e.stall = 1'b1;
         end else if (m_n == m_vec_at) begin
            e.pc_sel = 2'b01;
         end else begin
            e.in_h = 1'b1; m_handler = 1'b1; m_vec_at = -1;
         end
      end else if (m_handler) begin
         if (i_exc) begin
            e.halted = 1'b1; e.stall = 1'b1; e.flush = 1'b1;
            m_halted = 1'b1; m_handler = 1'b0; bump(3);
         end else if (i_eret) begin
            e.pc_sel = 2'b10; e.flush = 1'b1; m_handler = 1'b0;
         end else begin
            e.in_h = 1'b1;
         end
      end else if (i_irq || i_exc || i_eret) begin
         m_elr    = i_pc;
         m_esr    = i_irq ? 4'b0001 : (i_exc ? i_es : 4'b0010);
         e.ack    = i_irq;
         e.flush  = 1'b1;
         e.stall  = 1'b1;
         m_vec_at = m_n + FLUSH_CYC;
         bump(i_irq ? 0 : (i_exc ? 1 : 2));
      end
      e.elr = m_elr;
      e.esr = m_esr;
`ifdef EXC_STATS_EN
      e.stat = 16'(m_cnt[i_sel]);
`else
      e.stat = 16'h0000;
`endif
      sb.push_back(e);
      m_n = m_n + 1;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [1:0] sel);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, sel);
   endtask

   // Monitor: outputs are registered, so every cycle presents one response to check.
   always begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         exp_e        = sb.pop_front();
         got_e.ack    = irq_ack;
         got_e.flush  = flush;
         got_e.stall  = stall;
         got_e.pc_sel = pc_sel;
         got_e.elr    = elr;
         got_e.esr    = esr;
         got_e.in_h   = in_handler;
         got_e.halted = halted;
`ifdef EXC_STATS_EN
         got_e.stat   = stat;
`else
         got_e.stat   = 16'h0000;
`endif
         n_vec = n_vec + 1;
         if (got_e !== exp_e) begin
            n_err = n_err + 1;
            $display("FAIL vec %0d: got ack=%b fl=%b st=%b sel=%b elr=%h esr=%h inh=%b halt=%b stat=%0d, required ack=%b fl=%b st=%b sel=%b elr=%h esr=%h inh=%b halt=%b stat=%0d",
                     n_vec, got_e.ack, got_e.flush, got_e.stall, got_e.pc_sel, got_e.elr, got_e.esr,
                     got_e.in_h, got_e.halted, got_e.stat, exp_e.ack, exp_e.flush, exp_e.stall,
                     exp_e.pc_sel, exp_e.elr, exp_e.esr, exp_e.in_h, exp_e.halted, exp_e.stat);
         end
      end
   end

   initial begin
      int guard;
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);

      // IRQ entry at 0x40, then ERET; undefined-instruction entry at 0x10, then ERET.
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 64'h40, 2'd0);
      idle(6, 2'd0);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 64'h0, 2'd0);
      step(1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 64'h10, 2'd1);
      idle(6, 2'd1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 64'h0, 2'd1);
      idle(2, 2'd1);

      // IRQ and exception together, IRQ held through the handler, exception re-raised after ERET.
      step(1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 64'h80, 2'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 64'h84, 2'd0);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 64'h88, 2'd0);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 64'h8C, 2'd0);
      idle(6, 2'd0);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 64'h0, 2'd0);
      step(1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 64'h90, 2'd1);
      idle(5, 2'd1);

      // Double fault, held halted, then reset; reset in the middle of a flush.
      step(1'b1, 1'b0, 1'b1, 4'b0111, 1'b1, 64'h94, 2'd3);
      idle(20, 2'd3);
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd3);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 64'h200, 2'd0);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);
      idle(3, 2'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(!(($urandom_range(0, 99) < 2) || (m_halt_cyc >= 20)),
              $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
              4'($urandom_range(0, 15)), $urandom_range(0, 99) < 15,
              {$urandom(), $urandom()}, 2'($urandom_range(0, 3)));
      end

      // IRQ storm: 257 IRQ entries, then reset clears the counters.
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);
      guard = 0;
      while (m_cnt[0] < 257 && guard < 4000) begin
         step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, {$urandom(), $urandom()}, 2'd0);
         guard = guard + 1;
      end
      if (m_cnt[0] < 257) begin
         n_err = n_err + 1;
         $display("FAIL storm: reached %0d IRQ entries, required 257", m_cnt[0]);
      end
      idle(8, 2'd0);
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 64'h0, 2'd0);
      for (int s = 0; s < 4; s++) idle(1, 2'(s));

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_err = n_err + 1;
         $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
